fetch_prefetch_queue: RTL and testbench

//  Parametrised next-generation fetch stage. Owns the PC, issues pipelined requests to an

---
 rtl/fetch_prefetch_queue_if.sv | 28 ++
 rtl/fetch_prefetch_queue.sv | 162 ++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory port of the fetch stage: pipelined req/gnt requests,
// in-order rvalid responses. master = fetch side, slave = memory side.
interface fetch_prefetch_queue_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: owns the PC, keeps up to MAX_OUTST requests in
// flight and buffers returned instructions in a DEPTH-entry {pc, instr} FIFO
// feeding decode. A redirect flushes everything and drops in-flight replies.
// Optional feature macro: FETCH_PERF_EN (adds redirect / empty-cycle counters).
module fetch_prefetch_queue #(
    parameter int              XLEN      = 64,
    parameter int              ILEN      = 32,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   PCSrcE,
    input  logic [XLEN-1:0]        pc_target,
    input  logic                   StallF,
    fetch_prefetch_queue_if.master imem,
    output logic                   ValidF,
    output logic [ILEN-1:0]        InstrF,
    output logic [XLEN-1:0]        PCF,
    output logic [XLEN-1:0]        PCPlus4F
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_redirects,
    output logic [31:0]            perf_empty_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTST - 1);

    logic [XLEN-1:0] fetch_pc;
    logic [OW-1:0]   outst, outst_next, drop;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [TW-1:0]   tag_wr, tag_rd;
    logic            issue, grant, resp, push, pop;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] tag_mem   [MAX_OUTST];

    // A slot is reserved at grant (outst + count), so the FIFO cannot overflow.
    assign issue = reset_n && !PCSrcE && (int'(outst) < MAX_OUTST) &&
                   ((int'(outst) + int'(count)) < DEPTH);
    assign grant = issue && imem.imem_gnt;
    assign resp  = imem.imem_rvalid;
    assign push  = resp && !PCSrcE && (drop == '0);
    assign pop   = ValidF && !StallF && !PCSrcE;

    assign imem.imem_req  = issue;
    assign imem.imem_addr = fetch_pc;

    // Head of the FIFO is shown directly; outputs read as zero while empty.
    assign ValidF   = (count != '0);
    assign InstrF   = ValidF ? instr_mem[rd_ptr] : '0;
    assign PCF      = ValidF ? pc_mem[rd_ptr] : '0;
    assign PCPlus4F = ValidF ? (pc_mem[rd_ptr] + XLEN'(4)) : '0;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TAG_LAST) ? '0 : p + TW'(1);
    endfunction

    // In-flight count after this cycle's grant and response.
    always_comb begin
        outst_next = outst;
        if (grant && !resp)
            outst_next = outst + OW'(1);
        else if (!grant && resp)
            outst_next = outst - OW'(1);
    end

    // Fetch PC: redirect wins, otherwise advance on every accepted request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            fetch_pc <= RESET_PC;
        else if (PCSrcE)
            fetch_pc <= pc_target;
        else if (grant)
            fetch_pc <= fetch_pc + XLEN'(4);
    end

    // Outstanding requests and the number of stale replies still to discard.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outst <= '0;
            drop  <= '0;
        end else begin
            outst <= outst_next;
            if (PCSrcE)
                drop <= outst_next;
            else if (resp && (drop != '0))
                drop <= drop - OW'(1);
        end
    end

    // Tag queue pointers: one PC per live request, cleared on redirect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else if (PCSrcE) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (grant) tag_wr <= tag_inc(tag_wr);
            if (push)  tag_rd <= tag_inc(tag_rd);
        end
    end

    // Tag storage: remember the PC of each granted request.
    always_ff @(posedge clock) begin
        if (grant) tag_mem[tag_wr] <= fetch_pc;
    end

    // Instruction FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (PCSrcE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // Instruction FIFO storage: pair each reply with its request PC.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr]    <= tag_mem[tag_rd];
            instr_mem[wr_ptr] <= imem.imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters: redirect cycles and cycles with nothing for decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_redirects    <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (PCSrcE && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
            if (!ValidF && !PCSrcE && (perf_empty_cycles != '1))
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: a memory model drives req/gnt/rvalid with
// random latency, a reference model tracks the ideal sequential fetch stream,
// and a monitor pops the expected-instruction queue against decode outputs.
module tb_fetch_prefetch_queue;
    localparam int          XLEN      = 64;
    localparam int          ILEN      = 32;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [63:0] RESET_PC  = 64'h1000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        PCSrcE = 1'b0;
    logic        StallF = 1'b0;
    logic [63:0] pc_target = '0;
    logic        ValidF;
    logic [31:0] InstrF;
    logic [63:0] PCF, PCPlus4F;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects, perf_empty_cycles;
`endif

    fetch_prefetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN)) imem ();

    fetch_prefetch_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock), .reset_n(reset_n), .PCSrcE(PCSrcE), .pc_target(pc_target),
        .StallF(StallF), .imem(imem), .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF),
        .PCPlus4F(PCPlus4F)
`ifdef FETCH_PERF_EN
        , .perf_redirects(perf_redirects), .perf_empty_cycles(perf_empty_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct { logic [63:0] pc; bit ready; } exp_t;
    typedef struct { logic [63:0] addr; bit live; int due; } fly_t;

    exp_t        exp_q[$];   // granted, not flushed, not yet consumed by decode
    fly_t        fly_q[$];   // requests the memory still owes a reply
    int          n_chk = 0, n_fail = 0, cyc = 0, last_due = 0;
    int          redirects = 0, empties = 0;
    logic [63:0] exp_addr = RESET_PC;
    bit          seen_wrap = 0, mon_ev;

    int          gnt_pct = 100, lat_min = 1, lat_max = 1, stall_pct = 0, redir_pct = 0;
    bit          force_stall = 0, pend_redir = 0, redir_on_rvalid = 0;
    logic [63:0] pend_target = '0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int ready_cnt();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].ready) n++;
        return n;
    endfunction

    // One bus cycle: drive inputs at negedge, check request, commit model after posedge.
    task automatic step();
        bit rv, redir, g, er;
        int lat, due;
        @(negedge clock);
        cyc++;
        rv = (fly_q.size() > 0) && (fly_q[0].due <= cyc);
        redir = 0;
        if (pend_redir && (!redir_on_rvalid || rv)) begin
            redir = 1;
            pend_redir = 0;
            pc_target = pend_target;
        end else if (int'($urandom_range(99)) < redir_pct) begin
            redir = 1;
            pc_target = {$urandom(), $urandom()} & ~64'h3;
        end
        PCSrcE = redir;
        StallF = force_stall || (int'($urandom_range(99)) < stall_pct);
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rv ? instr_of(fly_q[0].addr) : $urandom();
        g = int'($urandom_range(99)) < gnt_pct;
        imem.imem_gnt = g;
        #1;
        er = !redir && (fly_q.size() < MAX_OUTST) && ((fly_q.size() + ready_cnt()) < DEPTH);
        check("imem_req", {63'd0, imem.imem_req}, {63'd0, er});
        if (er && imem.imem_req) check("imem_addr", imem.imem_addr, exp_addr);
        @(posedge clock);
        #1;
        if (redir) begin
            for (int i = 0; i < fly_q.size(); i++) fly_q[i].live = 0;
            exp_q.delete();
            exp_addr = pc_target;
            redirects++;
        end
        if (rv) begin
            fly_t f;
            f = fly_q.pop_front();
            if (f.live) begin
                for (int i = 0; i < exp_q.size(); i++)
                    if (!exp_q[i].ready) begin exp_q[i].ready = 1; break; end
            end
        end
        if (er && g) begin
            lat = int'($urandom_range(lat_max, lat_min));
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            fly_q.push_back('{addr: exp_addr, live: 1'b1, due: due});
            exp_q.push_back('{pc: exp_addr, ready: 1'b0});
            exp_addr = exp_addr + 64'd4;
        end
    endtask

    // Monitor: compare the decode head against the expected queue, pop on consume.
    always @(negedge clock) begin
        #2;
        if (reset_n) begin
            mon_ev = (exp_q.size() > 0) && exp_q[0].ready;
            check("ValidF", {63'd0, ValidF}, {63'd0, mon_ev});
            if (!mon_ev && !PCSrcE) empties++;
            if (mon_ev && ValidF) begin
                check("PCF", PCF, exp_q[0].pc);
                check("InstrF", {32'd0, InstrF}, {32'd0, instr_of(exp_q[0].pc)});
                check("PCPlus4F", PCPlus4F, exp_q[0].pc + 64'd4);
                if (exp_q[0].pc == 64'hFFFF_FFFF_FFFF_FFFC && PCPlus4F == 64'd0) seen_wrap = 1;
                if (!StallF && !PCSrcE) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata = '0;
        repeat (2) @(negedge clock);
        #1;
        check("reset imem_req", {63'd0, imem.imem_req}, 64'd0);
        check("reset ValidF", {63'd0, ValidF}, 64'd0);
        check("reset PCF", PCF, 64'd0);
        check("reset InstrF", {32'd0, InstrF}, 64'd0);
        check("reset PCPlus4F", PCPlus4F, 64'd0);
        reset_n = 1'b1;

        // Sequential fetch from RESET_PC with a 1-cycle memory.
        repeat (20) step();

        // Long stall with gnt always high, then release.
        force_stall = 1;
        repeat (10) step();
        force_stall = 0;
        repeat (10) step();

        // Redirect to 0x2000 while two requests are in flight at latency 3.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && fly_q.size() != 2; i++) step();
        check("two in flight", 64'(fly_q.size()), 64'd2);
        pend_target = 64'h2000; pend_redir = 1;
        repeat (15) step();

        // Redirect coincident with rvalid and StallF.
        force_stall = 1; redir_on_rvalid = 1;
        pend_target = 64'h3000; pend_redir = 1;
        for (int i = 0; i < 20 && pend_redir; i++) step();
        check("redirect on rvalid taken", {63'd0, pend_redir}, 64'd0);
        pend_redir = 0; force_stall = 0; redir_on_rvalid = 0;
        repeat (10) step();

        // PC wrap at the top of the address space.
        lat_min = 1; lat_max = 1;
        pend_target = 64'hFFFF_FFFF_FFFF_FFF8; pend_redir = 1;
        repeat (20) step();
        check("wrap head seen", {63'd0, seen_wrap}, 64'd1);

        // Random traffic: variable latency, sparse grants, stalls and redirects.
        gnt_pct = 70; lat_min = 1; lat_max = 5; stall_pct = 30; redir_pct = 3;
        repeat (2000) step();

        // Quiet tail, then counter comparison.
        redir_pct = 0; stall_pct = 0; gnt_pct = 100;
        repeat (20) step();
        @(negedge clock);
        #1;
`ifdef FETCH_PERF_EN
        check("perf_redirects", {32'd0, perf_redirects}, 64'(redirects));
        check("perf_empty_cycles", {32'd0, perf_empty_cycles}, 64'(empties));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
